// File: rtl/flash_ctrl.sv
// flash_ctrl: shares one flash driver between the instruction-fetch port
// (port 0, read only) and the data port (port 1: read, program, erase).
// Round-robin arbitration, one driver operation at a time using a
// four-phase enable/ack handshake, and a watchdog that aborts a driver
// operation that never completes.
module flash_ctrl #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic [21:0] p0_addr,
    output logic [15:0] p0_rdata,
    output logic        p0_ack,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic [1:0]  p1_op,
    input  logic [21:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic [15:0] p1_rdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [21:0] drv_addr,
    output logic [15:0] drv_data_in,
    input  logic [15:0] drv_data_out,
    output logic        drv_read,
    output logic        drv_write,
    output logic        drv_erase,
    input  logic        drv_ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ISSUE   = 2'b01,
        S_RELEASE = 2'b10,
        S_RESP    = 2'b11
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;          // 0: port 0 wins a tie, 1: port 1 wins
    logic        win_q, win_d;        // port currently being served
    logic [1:0]  op_q, op_d;
    logic [23:0] cnt_q, cnt_d;
    logic [21:0] drv_addr_q, drv_addr_d;
    logic [15:0] drv_data_in_q, drv_data_in_d;
    logic        drv_read_q, drv_read_d;
    logic        drv_write_q, drv_write_d;
    logic        drv_erase_q, drv_erase_d;
    logic [15:0] p0_rdata_q, p0_rdata_d;
    logic [15:0] p1_rdata_q, p1_rdata_d;
    logic        p0_ack_q, p0_ack_d;
    logic        p0_err_q, p0_err_d;
    logic        p1_ack_q, p1_ack_d;
    logic        p1_err_q, p1_err_d;
    logic        busy_q, busy_d;

    logic        both_s;
    logic        win_s;
    logic [1:0]  grant_op_s;
    logic        timeout_s;

    // Pick the winner among the current requesters; a tie goes to the rr pointer
    always_comb begin
        both_s = p0_req & p1_req;
        if (both_s) begin
            win_s = rr_q;
        end else if (p1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        grant_op_s = win_s ? p1_op : OP_READ;
        timeout_s  = (cnt_q == (TIMEOUT_CYCLES - 24'd1));
    end

    // Next-state and registered-output computation for the controller FSM
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        win_d         = win_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        drv_addr_d    = drv_addr_q;
        drv_data_in_d = drv_data_in_q;
        drv_read_d    = drv_read_q;
        drv_write_d   = drv_write_q;
        drv_erase_d   = drv_erase_q;
        p0_rdata_d    = p0_rdata_q;
        p1_rdata_d    = p1_rdata_q;
        p0_ack_d      = 1'b0;
        p0_err_d      = 1'b0;
        p1_ack_d      = 1'b0;
        p1_err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 24'd0;
                // A driver still showing ack is not ready yet: hold off grants.
                if (!drv_ack && (p0_req || p1_req)) begin
                    win_d         = win_s;
                    op_d          = grant_op_s;
                    drv_addr_d    = win_s ? p1_addr : p0_addr;
                    drv_data_in_d = p1_wdata;
                    if (both_s) begin
                        rr_d = ~win_s;
                    end else begin
                        rr_d = rr_q;
                    end
                    if (win_s && (p1_op == 2'b11)) begin
                        state_d  = S_RESP;
                        p1_ack_d = 1'b1;
                        p1_err_d = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        drv_read_d  = (grant_op_s == OP_READ);
                        drv_write_d = (grant_op_s == OP_PROG);
                        drv_erase_d = (grant_op_s == OP_ERASE);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 24'd1;
                if (timeout_s) begin
                    drv_read_d  = 1'b0;
                    drv_write_d = 1'b0;
                    drv_erase_d = 1'b0;
                    state_d     = S_RESP;
                    p0_ack_d    = ~win_q;
                    p0_err_d    = ~win_q;
                    p1_ack_d    = win_q;
                    p1_err_d    = win_q;
                end else if (drv_ack) begin
                    if (op_q == OP_READ) begin
                        if (win_q) begin
                            p1_rdata_d = drv_data_out;
                        end else begin
                            p0_rdata_d = drv_data_out;
                        end
                    end else begin
                        p0_rdata_d = p0_rdata_q;
                    end
                    drv_read_d  = 1'b0;
                    drv_write_d = 1'b0;
                    drv_erase_d = 1'b0;
                    state_d     = S_RELEASE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_RELEASE: begin
                cnt_d = cnt_q + 24'd1;
                if (timeout_s) begin
                    state_d  = S_RESP;
                    p0_ack_d = ~win_q;
                    p0_err_d = ~win_q;
                    p1_ack_d = win_q;
                    p1_err_d = win_q;
                end else if (!drv_ack) begin
                    state_d  = S_RESP;
                    p0_ack_d = ~win_q;
                    p1_ack_d = win_q;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                drv_read_d  = 1'b0;
                drv_write_d = 1'b0;
                drv_erase_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rr_q          <= 1'b0;
            win_q         <= 1'b0;
            op_q          <= 2'b00;
            cnt_q         <= 24'd0;
            drv_addr_q    <= 22'd0;
            drv_data_in_q <= 16'd0;
            drv_read_q    <= 1'b0;
            drv_write_q   <= 1'b0;
            drv_erase_q   <= 1'b0;
            p0_rdata_q    <= 16'd0;
            p1_rdata_q    <= 16'd0;
            p0_ack_q      <= 1'b0;
            p0_err_q      <= 1'b0;
            p1_ack_q      <= 1'b0;
            p1_err_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            win_q         <= win_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            drv_addr_q    <= drv_addr_d;
            drv_data_in_q <= drv_data_in_d;
            drv_read_q    <= drv_read_d;
            drv_write_q   <= drv_write_d;
            drv_erase_q   <= drv_erase_d;
            p0_rdata_q    <= p0_rdata_d;
            p1_rdata_q    <= p1_rdata_d;
            p0_ack_q      <= p0_ack_d;
            p0_err_q      <= p0_err_d;
            p1_ack_q      <= p1_ack_d;
            p1_err_q      <= p1_err_d;
            busy_q        <= busy_d;
        end
    end

    assign p0_rdata    = p0_rdata_q;
    assign p0_ack      = p0_ack_q;
    assign p0_err      = p0_err_q;
    assign p1_rdata    = p1_rdata_q;
    assign p1_ack      = p1_ack_q;
    assign p1_err      = p1_err_q;
    assign drv_addr    = drv_addr_q;
    assign drv_data_in = drv_data_in_q;
    assign drv_read    = drv_read_q;
    assign drv_write   = drv_write_q;
    assign drv_erase   = drv_erase_q;
    assign busy        = busy_q;

endmodule
